// File: rtl/uart_mem_loader.sv
// uart_mem_loader: packs received UART bytes little-endian into 32-bit words
// and writes them through an Avalon-style slave write port, starting at a
// base word address. Each transfer is armed by a start pulse carrying the
// base address and byte length.
module uart_mem_loader #(
    parameter int ADDR_W  = 10,
    parameter int LEN_W   = 12,
    parameter int TIMEOUT = 50000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  byte_len,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    input  logic              rx_error,
    output logic [ADDR_W-1:0] address,
    output logic [3:0]        byteenable,
    output logic              chipselect,
    output logic              write,
    output logic [31:0]       writedata,
    output logic              clken,
    output logic              busy,
    output logic              done,
    output logic              timed_out,
    output logic              err_seen,
    output logic [ADDR_W:0]   words_written
);

    localparam int IDLE_W = $clog2(TIMEOUT + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_FLUSH, S_DONE} state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] base_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  byte_cnt_q;
    logic [1:0]        lane_idx_q;
    logic [31:0]       pack_q;
    logic [IDLE_W-1:0] idle_q;

    logic [ADDR_W-1:0] address_q;
    logic [3:0]        byteenable_q;
    logic              chipselect_q;
    logic              write_q;
    logic [31:0]       writedata_q;
    logic              busy_q;
    logic              done_q;
    logic              timed_out_q;
    logic              err_seen_q;
    logic [ADDR_W:0]   words_written_q;

    // Packing word with the incoming byte merged into the current lane, plus
    // lane masks: be_fill includes the lane being filled now, be_part only
    // the lanes already held in pack_q (used by the timeout flush).
    logic [31:0] pack_merged;
    logic [3:0]  be_fill;
    logic [3:0]  be_part;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign pack_merged[gi*8 +: 8] = (lane_idx_q == 2'(gi)) ? rx_data : pack_q[gi*8 +: 8];
            assign be_fill[gi] = (2'(gi) <= lane_idx_q);
            assign be_part[gi] = (2'(gi) <  lane_idx_q);
        end
    endgenerate

    logic byte_ok;
    logic last_byte;
    logic word_full;

    assign byte_ok   = rx_valid && !rx_error;
    assign last_byte = ((byte_cnt_q + LEN_W'(1)) == len_q);
    assign word_full = (lane_idx_q == 2'd3) || last_byte;

    // Transfer FSM with all outputs registered; write/chipselect default low
    // so each issued write lasts exactly one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= S_IDLE;
            base_q          <= '0;
            len_q           <= '0;
            byte_cnt_q      <= '0;
            lane_idx_q      <= '0;
            pack_q          <= '0;
            idle_q          <= '0;
            address_q       <= '0;
            byteenable_q    <= '0;
            chipselect_q    <= 1'b0;
            write_q         <= 1'b0;
            writedata_q     <= '0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            timed_out_q     <= 1'b0;
            err_seen_q      <= 1'b0;
            words_written_q <= '0;
        end else begin
            write_q      <= 1'b0;
            chipselect_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        base_q          <= base_addr;
                        len_q           <= byte_len;
                        byte_cnt_q      <= '0;
                        lane_idx_q      <= '0;
                        pack_q          <= '0;
                        idle_q          <= '0;
                        timed_out_q     <= 1'b0;
                        err_seen_q      <= 1'b0;
                        words_written_q <= '0;
                        if (byte_len == '0) begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_COLLECT;
                            busy_q  <= 1'b1;
                            done_q  <= 1'b0;
                        end
                    end
                end
                S_COLLECT: begin
                    if (rx_valid) begin
                        idle_q <= '0;
                        if (!byte_ok) begin
                            err_seen_q <= 1'b1;
                        end else begin
                            byte_cnt_q <= byte_cnt_q + LEN_W'(1);
                            if (word_full) begin
                                // Hand the word to the write register; packing restarts empty.
                                write_q         <= 1'b1;
                                chipselect_q    <= 1'b1;
                                address_q       <= base_q + words_written_q[ADDR_W-1:0];
                                writedata_q     <= pack_merged;
                                byteenable_q    <= be_fill;
                                words_written_q <= words_written_q + 1'b1;
                                pack_q          <= '0;
                                lane_idx_q      <= '0;
                                if (last_byte) begin
                                    state_q <= S_FLUSH;
                                end
                            end else begin
                                pack_q     <= pack_merged;
                                lane_idx_q <= lane_idx_q + 2'd1;
                            end
                        end
                    end else if (idle_q == IDLE_LAST) begin
                        // Link went quiet: write out whatever lanes are held, then finish.
                        state_q     <= S_FLUSH;
                        timed_out_q <= 1'b1;
                        idle_q      <= '0;
                        if (lane_idx_q != 2'd0) begin
                            write_q         <= 1'b1;
                            chipselect_q    <= 1'b1;
                            address_q       <= base_q + words_written_q[ADDR_W-1:0];
                            writedata_q     <= pack_q;
                            byteenable_q    <= be_part;
                            words_written_q <= words_written_q + 1'b1;
                            pack_q          <= '0;
                            lane_idx_q      <= '0;
                        end
                    end else begin
                        idle_q <= idle_q + IDLE_W'(1);
                    end
                end
                S_FLUSH: begin
                    // Any final write is on the bus during this cycle.
                    state_q <= S_DONE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign address       = address_q;
    assign byteenable    = byteenable_q;
    assign chipselect    = chipselect_q;
    assign write         = write_q;
    assign writedata     = writedata_q;
    assign clken         = 1'b1;
    assign busy          = busy_q;
    assign done          = done_q;
    assign timed_out     = timed_out_q;
    assign err_seen      = err_seen_q;
    assign words_written = words_written_q;

endmodule
